reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Parametrised register scoreboard for the in-order pipeline. It tracks, per architectural register, how many register-file writes are in flight between decode and writeback, and raises a read-after-write hazard for decode. It is the successor to the single-bit invalid table: it adds multiple outstanding writes per register, several writeback ports, pipeline flush, and an issue-full back-pressure signal. It sits beside the ID stage and is fed by ID (issue) and WB (retire).

## Interface
- NREG, default 8: number of architectural registers.
- ADRW, default 3: register address width; must satisfy 2^ADRW >= NREG.
- CNTW, default 2: per-register pending-write counter width; saturation value CMAX = 2^CNTW-1.
- NRET, default 1: number of writeback (retire) ports.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- issue  in  1  ID issues an instruction that writes a register.
- issue_adr  in  ADRW  destination of the issued write.
- retire  in  NRET  per-port writeback strobe.
- retire_adr  in  NRET*ADRW  per-port destination; port k occupies bits [k*ADRW +: ADRW].
- flush  in  1  discard all in-flight writes (branch or mispredict).
- src_valid  in  2  decode reads source 0 / source 1.
- src_adr  in  2*ADRW  source addresses; source k occupies bits [k*ADRW +: ADRW].
- register_invalid  out  NREG  bit r = 1 when cnt[r] != 0.
- hazard  out  1  an enabled source is invalid; ID must stall.
- issue_full  out  1  cnt[issue_adr] == CMAX; ID must stall.
- underflow  out  1  sticky error flag: a retire arrived with no matching pending write.

## Operation
- State: cnt[r], CNTW bits wide, for each r in 0..NREG-1, plus the underflow flag.
- Each cycle computes next = cnt[r] + inc[r] - dec[r]:
  - inc[r] = issue && !issue_full && issue_adr == r;
  - dec[r] = number of asserted retire ports addressing r (0..NRET).
- Priority: reset > flush > increment/decrement.
  - flush clears every counter. A retire or issue in the same cycle is ignored.
  - underflow is not cleared by flush.
- Issue while issue_full: dropped, counter unchanged.
- Same-cycle issue and retire on one register: net change (e.g. cnt 1, issue + retire -> 1).
- Retire decrements that would take cnt[r] below 0:
  - counter clamps at 0;
  - underflow is set and held until reset.
- Addresses >= NREG: issue and retire are ignored; a source at such an address reads as valid.
- hazard = OR over k of (src_valid[k] && register_invalid[src_adr_k]), adjusted by the forwarding rule in Configuration.
- hazard and issue_full are combinational from current state and inputs. They do not depend on this cycle's issue.

## Timing
- Reset values: all cnt = 0, register_invalid = 0, underflow = 0, hazard = 0, issue_full = 0.
- Issue at edge N -> register_invalid bit set from cycle N+1. The instruction right behind the issuer therefore sees the hazard.
- Retire at edge N -> bit cleared from cycle N+1 (without forwarding).
- Flush at edge N -> all bits 0 from cycle N+1.
- Reset asserted mid-operation clears all state at the next edge, regardless of the other inputs.
- No multi-cycle handshake. ID holds its instruction while hazard or issue_full is high and re-presents it the following cycle.

## Configuration
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: writeback forwarding into ID is available.
  - A source counts as valid when cnt[src] equals the number of retires addressing it this cycle. The in-flight write completes this cycle and its value is bypassed.
  - hazard is then low in the retire cycle itself.
- Undefined: hazard uses register_invalid only. A dependent instruction stalls one extra cycle.
- Neither setting changes counter update behaviour.

## Test plan
- Reset, then issue r3 at cycle 1 -> register_invalid = 0x08 from cycle 2. src_valid = 01 with source 0 = r3 -> hazard = 1. Retire r3 -> bits 0x00 the next cycle.
- CNTW = 2: issue r5 three times -> cnt 3, issue_full = 1. A fourth issue is dropped. One retire -> issue_full = 0, cnt 2.
- NRET = 2: cnt[r1] = 2, both ports retire r1 in one cycle -> cnt 0 next cycle, underflow = 0.
- cnt[r2] = 1, issue r2 and retire r2 in the same cycle -> cnt stays 1, bit 2 stays set.
- Issue r4 and r6, then flush concurrently with a retire of r4 -> all bits 0 next cycle, underflow = 0. A retire of r6 afterwards -> underflow = 1, persisting until reset.
- With SCOREBOARD_WB_BYPASS_EN: cnt[r7] = 1, retire r7, source 1 = r7 in the same cycle -> hazard = 0. Without the macro -> hazard = 1.

Source files
------------

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_scoreboard: per-register pending-write counters for the in-order     |
// | pipeline; raises RAW hazard and issue-full stalls for the ID stage.      |
// | Optional feature macro: SCOREBOARD_WB_BYPASS_EN (writeback forwarding).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int ADRW = 3,
  parameter int CNTW = 2,
  parameter int NRET = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic [ADRW-1:0]      issue_adr,
  input  logic [NRET-1:0]      retire,
  input  logic [NRET*ADRW-1:0] retire_adr,
  input  logic                 flush,
  input  logic [1:0]           src_valid,
  input  logic [2*ADRW-1:0]    src_adr,
  output logic [NREG-1:0]      register_invalid,
  output logic                 hazard,
  output logic                 issue_full,
  output logic                 underflow
);

  localparam logic [CNTW-1:0] C_CMAX = '1;

  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic            underflow_q;
  logic            underflow_d;
  int              w_dec [NREG];
  int              w_sum [NREG];

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_inv
      assign register_invalid[r] = (cnt_q[r] != '0);
    end
  endgenerate

  assign underflow = underflow_q;

  // Retires addressing a register; out-of-range addresses never match.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_dec[r] = 0;
      for (int k = 0; k < NRET; k++) begin
        if (retire[k] && (retire_adr[k*ADRW +: ADRW] == ADRW'(r))) begin
          w_dec[r] = w_dec[r] + 1;
        end
      end
    end
  end

  always_comb begin
    issue_full = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if ((issue_adr == ADRW'(r)) && (cnt_q[r] == C_CMAX)) begin
        issue_full = 1'b1;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < NREG; r++) begin
        if (src_valid[s] && (src_adr[s*ADRW +: ADRW] == ADRW'(r))) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
          // Writes completing this cycle are forwarded, so only leftovers stall.
          if (int'(cnt_q[r]) != w_dec[r]) begin
            hazard = 1'b1;
          end
`else
          if (register_invalid[r]) begin
            hazard = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    underflow_d = underflow_q;
    for (int r = 0; r < NREG; r++) begin
      w_sum[r] = int'(cnt_q[r])
               + ((issue && !issue_full && (issue_adr == ADRW'(r))) ? 1 : 0)
               - w_dec[r];
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (w_sum[r] < 0) begin
        cnt_d[r]    = '0;
        underflow_d = 1'b1;
      end else begin
        cnt_d[r] = CNTW'(w_sum[r]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      underflow_q <= underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_scoreboard: directed bench with a pending-write count model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reg_scoreboard;

  localparam int NREG = 8;
  localparam int ADRW = 3;
  localparam int CNTW = 2;
  localparam int NRET = 2;
  localparam int CMAX = (1 << CNTW) - 1;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue;
  logic [ADRW-1:0]      issue_adr;
  logic [NRET-1:0]      retire;
  logic [NRET*ADRW-1:0] retire_adr;
  logic                 flush;
  logic [1:0]           src_valid;
  logic [2*ADRW-1:0]    src_adr;
  logic [NREG-1:0]      register_invalid;
  logic                 hazard;
  logic                 issue_full;
  logic                 underflow;

  int  total = 0;
  int  bad = 0;
  int  mcnt [NREG];
  bit  muf = 1'b0;
  bit  check_en = 1'b0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(NREG), .ADRW(ADRW), .CNTW(CNTW), .NRET(NRET)) dut (
    .clk(clk), .reset(reset), .issue(issue), .issue_adr(issue_adr),
    .retire(retire), .retire_adr(retire_adr), .flush(flush),
    .src_valid(src_valid), .src_adr(src_adr),
    .register_invalid(register_invalid), .hazard(hazard),
    .issue_full(issue_full), .underflow(underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: counts of outstanding writes ----------------
  function automatic int n_ret(input int a);
    int n = 0;
    for (int k = 0; k < NRET; k++)
      if (retire[k] && int'(retire_adr[k*ADRW +: ADRW]) == a) n++;
    return n;
  endfunction

  function automatic int exp_inv();
    int v = 0;
    for (int r = 0; r < NREG; r++) if (mcnt[r] != 0) v |= (1 << r);
    return v;
  endfunction

  function automatic int exp_full();
    int a = int'(issue_adr);
    return (a < NREG && mcnt[a] == CMAX) ? 1 : 0;
  endfunction

  function automatic int exp_hazard();
    int h = 0;
    for (int s = 0; s < 2; s++) begin
      int a = int'(src_adr[s*ADRW +: ADRW]);
      if (src_valid[s] && a < NREG) begin
        if (BYP != 0) begin
          if (mcnt[a] != n_ret(a)) h = 1;
        end else begin
          if (mcnt[a] != 0) h = 1;
        end
      end
    end
    return h;
  endfunction

  always @(posedge clk) begin
    int nxt [NREG];
    if (reset) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
      muf = 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    end else begin
      for (int r = 0; r < NREG; r++) nxt[r] = mcnt[r];
      if (issue && int'(issue_adr) < NREG && mcnt[int'(issue_adr)] < CMAX)
        nxt[int'(issue_adr)]++;
      for (int k = 0; k < NRET; k++)
        if (retire[k] && int'(retire_adr[k*ADRW +: ADRW]) < NREG)
          nxt[int'(retire_adr[k*ADRW +: ADRW])]--;
      for (int r = 0; r < NREG; r++) begin
        if (nxt[r] < 0) begin
          nxt[r] = 0;
          muf = 1'b1;
        end
        mcnt[r] = nxt[r];
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_invalid", int'(register_invalid), exp_inv());
      chk("model_hazard", int'(hazard), exp_hazard());
      chk("model_full", int'(issue_full), exp_full());
      chk("model_underflow", int'(underflow), int'(muf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    reset = 1'b0; issue = 1'b0; issue_adr = '0; retire = '0;
    retire_adr = '0; flush = 1'b0; src_valid = '0; src_adr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input int a);
    issue = 1'b1; issue_adr = ADRW'(a);
  endtask

  task automatic do_retire(input int port, input int a);
    retire[port] = 1'b1;
    retire_adr[port*ADRW +: ADRW] = ADRW'(a);
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    idle();
    reset = 1'b1;
    tick(); tick();
    check_en = 1'b1;
    reset = 1'b0;
    #1;
    chk("reset_invalid", int'(register_invalid), 0);
    chk("reset_hazard", int'(hazard), 0);
    chk("reset_full", int'(issue_full), 0);
    chk("reset_underflow", int'(underflow), 0);

    // Issue r3, dependent read, then retire.
    do_issue(3); tick(); idle(); #1;
    chk("issue_r3_invalid", int'(register_invalid), 'h08);
    src_valid = 2'b01; src_adr[0 +: ADRW] = 3'd3; #1;
    chk("raw_hazard_r3", int'(hazard), 1);
    do_retire(0, 3); #1;
    chk("retire_cycle_hazard_r3", int'(hazard), (BYP != 0) ? 0 : 1);
    tick(); idle(); #1;
    chk("retire_r3_invalid", int'(register_invalid), 'h00);

    // Saturate r5, drop a fourth issue, retire one.
    do_issue(5); tick(); tick(); tick(); #1;
    chk("r5_full", int'(issue_full), 1);
    tick(); idle(); issue_adr = 3'd5; #1;
    chk("r5_full_after_drop", int'(issue_full), 1);
    do_retire(0, 5); tick(); idle(); issue_adr = 3'd5; #1;
    chk("r5_not_full", int'(issue_full), 0);
    chk("r5_still_invalid", int'(register_invalid), 'h20);
    do_retire(0, 5); do_retire(1, 5); tick(); idle(); #1;
    chk("r5_drained", int'(register_invalid), 'h00);
    chk("r5_no_underflow", int'(underflow), 0);

    // Two ports retire r1 together.
    do_issue(1); tick(); tick(); idle();
    do_retire(0, 1); do_retire(1, 1); tick(); idle(); #1;
    chk("dual_retire_r1_invalid", int'(register_invalid), 'h00);
    chk("dual_retire_r1_underflow", int'(underflow), 0);

    // Same-cycle issue and retire on r2 nets to zero change.
    do_issue(2); tick(); idle();
    do_issue(2); do_retire(0, 2); tick(); idle(); #1;
    chk("r2_net_invalid", int'(register_invalid), 'h04);
    do_retire(1, 2); tick(); idle(); #1;
    chk("r2_cleared", int'(register_invalid), 'h00);

    // Flush wins over a concurrent retire; a later stray retire underflows.
    do_issue(4); tick(); do_issue(6); tick(); idle();
    flush = 1'b1; do_retire(0, 4); tick(); idle(); #1;
    chk("flush_invalid", int'(register_invalid), 'h00);
    chk("flush_underflow", int'(underflow), 0);
    do_retire(0, 6); tick(); idle(); #1;
    chk("stray_retire_underflow", int'(underflow), 1);
    tick(); tick(); flush = 1'b1; tick(); idle(); #1;
    chk("underflow_sticky", int'(underflow), 1);

    // Retire-cycle read of r7 on source 1.
    do_issue(7); tick(); idle();
    do_retire(1, 7); src_valid = 2'b10; src_adr[ADRW +: ADRW] = 3'd7; #1;
    chk("bypass_r7_hazard", int'(hazard), (BYP != 0) ? 0 : 1);
    tick(); idle(); #1;
    chk("r7_cleared", int'(register_invalid), 'h00);

    // Reset mid-operation beats a concurrent issue.
    do_issue(0); tick(); #1;
    chk("r0_invalid", int'(register_invalid), 'h01);
    reset = 1'b1; tick(); idle(); #1;
    chk("midreset_invalid", int'(register_invalid), 'h00);
    chk("midreset_underflow", int'(underflow), 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
